simd_wb_dispatch: RTL



---
 rtl/simd_wb_dispatch.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/simd_wb_dispatch.sv
// simd_wb_dispatch: receive-side endpoint for the SIMD execute-control write-back bundle.
// Each cycle with a non-zero request mask is queued together with its write address.
// Multi-bit masks are serialised into single-namespace writes, lowest namespace first,
// over a valid/ready handshake. When the loop ends, the queue drains and drain_done pulses.
// Optional build macro: SIMD_WB_PERF_CNT_EN adds saturating write/stall counters.
module simd_wb_dispatch #(
  parameter int NS_ID_BITS        = 3,
  parameter int NS_INDEX_ID_BITS  = 5,
  parameter int BASE_STRIDE_WIDTH = 4*(NS_INDEX_ID_BITS+NS_ID_BITS),
  parameter int NUM_NS            = 6,
  parameter int NS_SEL_BITS       = 3,
  parameter int FIFO_DEPTH        = 8,
  parameter int CNT_BITS          = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_loop_in,
  input  logic [NUM_NS-1:0]            buf_wr_req_in,
  input  logic [BASE_STRIDE_WIDTH-1:0] buf_wr_addr_in,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [NS_SEL_BITS-1:0]       wr_ns_sel,
  output logic [BASE_STRIDE_WIDTH-1:0] wr_addr,
  output logic [CNT_BITS-1:0]          fifo_count,
  output logic                         almost_full,
  output logic                         overflow_err,
  output logic                         busy,
  output logic                         drain_done
`ifdef SIMD_WB_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_wr_count,
  output logic [31:0]                  perf_stall_count
`endif
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam logic [CNT_BITS-1:0] L_CNT_FULL  = CNT_BITS'(FIFO_DEPTH);
  localparam logic [CNT_BITS-1:0] L_CNT_AFULL = CNT_BITS'(FIFO_DEPTH - 2);
  localparam logic [CNT_BITS-1:0] L_CNT_ONE   = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] L_CNT_ZERO  = CNT_BITS'(0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACTIVE = 2'b01,
    S_DRAIN  = 2'b10
  } state_t;

  // Index of the lowest set bit of a mask; zero when the mask is empty.
  function automatic logic [NS_SEL_BITS-1:0] f_lowest_idx(input logic [NUM_NS-1:0] mask);
    logic [NS_SEL_BITS-1:0] idx;
    idx = '0;
    for (int i = NUM_NS-1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = NS_SEL_BITS'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Queue storage and pointers
  logic [NUM_NS-1:0]            r_mem_mask [FIFO_DEPTH];
  logic [BASE_STRIDE_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
  logic [PTR_BITS-1:0]          r_wr_ptr;
  logic [PTR_BITS-1:0]          r_rd_ptr;
  logic [CNT_BITS-1:0]          r_count;

  // Head working copy and registered outputs
  logic [NUM_NS-1:0]            r_rem_mask;
  logic [BASE_STRIDE_WIDTH-1:0] r_head_addr;
  logic [NS_SEL_BITS-1:0]       r_ns_sel;
  logic                         r_wr_valid;
  logic                         r_almost_full;

  // Control state
  state_t                       r_state;
  logic                         r_overflow_err;
  logic                         r_busy;
  logic                         r_drain_done;

  // Combinational next-state terms
  logic                         w_push_req;
  logic                         w_fire;
  logic [NUM_NS-1:0]            w_rem_clr;
  logic                         w_pop;
  logic                         w_full;
  logic                         w_push;
  logic                         w_drop;
  logic [PTR_BITS-1:0]          w_rd_ptr_inc;
  logic [CNT_BITS-1:0]          w_count_nxt;
  logic [NUM_NS-1:0]            w_rem_nxt;
  logic [BASE_STRIDE_WIDTH-1:0] w_addr_nxt;
  state_t                       w_state_nxt;
  logic                         w_enter_active;
  logic                         w_drain_done_nxt;
  logic                         w_overflow_nxt;

  // Handshake, push/pop decisions and next head contents
  always_comb begin
    w_push_req   = |buf_wr_req_in;
    w_fire       = r_wr_valid & wr_ready;
    w_rem_clr    = r_rem_mask & (r_rem_mask - NUM_NS'(1));
    w_pop        = w_fire & (w_rem_clr == '0);
    w_full       = (r_count == L_CNT_FULL);
    // A full queue still accepts when the head leaves in the same cycle.
    w_push       = w_push_req & (~w_full | w_pop);
    w_drop       = w_push_req & ~w_push;
    w_rd_ptr_inc = r_rd_ptr + PTR_BITS'(1);
    w_rem_nxt    = r_rem_mask;
    w_addr_nxt   = r_head_addr;

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + L_CNT_ONE;
      2'b01:   w_count_nxt = r_count - L_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase

    if (w_pop) begin
      if (r_count > L_CNT_ONE) begin
        // Next queued entry becomes head without a bubble.
        w_rem_nxt  = r_mem_mask[w_rd_ptr_inc];
        w_addr_nxt = r_mem_addr[w_rd_ptr_inc];
      end else if (w_push) begin
        // Last entry leaves while a new one arrives: the new one is head.
        w_rem_nxt  = buf_wr_req_in;
        w_addr_nxt = buf_wr_addr_in;
      end else begin
        w_rem_nxt  = '0;
        w_addr_nxt = '0;
      end
    end else if (w_fire) begin
      w_rem_nxt = w_rem_clr;
    end else if ((r_count == L_CNT_ZERO) && w_push) begin
      w_rem_nxt  = buf_wr_req_in;
      w_addr_nxt = buf_wr_addr_in;
    end else begin
      w_rem_nxt  = r_rem_mask;
      w_addr_nxt = r_head_addr;
    end
  end

  // Loop-control FSM next state, drain completion and sticky overflow
  always_comb begin
    w_state_nxt      = r_state;
    w_enter_active   = 1'b0;
    w_drain_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_loop_in) begin
          w_state_nxt    = S_ACTIVE;
          w_enter_active = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (!in_loop_in) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_DRAIN: begin
        if (in_loop_in) begin
          w_state_nxt = S_ACTIVE;
        end else if (r_count == L_CNT_ZERO) begin
          w_state_nxt      = S_IDLE;
          w_drain_done_nxt = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A drop in the same cycle as loop entry is newer news and wins.
    if (w_drop) begin
      w_overflow_nxt = 1'b1;
    end else if (w_enter_active) begin
      w_overflow_nxt = 1'b0;
    end else begin
      w_overflow_nxt = r_overflow_err;
    end
  end

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_mask[i] <= '0;
        r_mem_addr[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_mask[r_wr_ptr] <= buf_wr_req_in;
        r_mem_addr[r_wr_ptr] <= buf_wr_addr_in;
        r_wr_ptr             <= r_wr_ptr + PTR_BITS'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_count <= w_count_nxt;
    end
  end

  // Head working mask and registered write-port outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem_mask    <= '0;
      r_head_addr   <= '0;
      r_ns_sel      <= '0;
      r_wr_valid    <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      r_rem_mask    <= w_rem_nxt;
      r_head_addr   <= w_addr_nxt;
      r_ns_sel      <= f_lowest_idx(w_rem_nxt);
      r_wr_valid    <= (w_count_nxt != L_CNT_ZERO);
      r_almost_full <= (w_count_nxt >= L_CNT_AFULL);
    end
  end

  // Loop-control state, status flags and drain completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_overflow_err <= 1'b0;
      r_busy         <= 1'b0;
      r_drain_done   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_overflow_err <= w_overflow_nxt;
      r_busy         <= (w_state_nxt != S_IDLE) || (w_count_nxt != L_CNT_ZERO);
      r_drain_done   <= w_drain_done_nxt;
    end
  end

`ifdef SIMD_WB_PERF_CNT_EN
  logic [31:0] r_perf_wr;
  logic [31:0] r_perf_stall;

  // Saturating counters of completed writes and back-pressured cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_wr    <= 32'd0;
      r_perf_stall <= 32'd0;
    end else if (w_enter_active) begin
      r_perf_wr    <= 32'd0;
      r_perf_stall <= 32'd0;
    end else begin
      if (w_fire && (r_perf_wr != 32'hFFFF_FFFF)) begin
        r_perf_wr <= r_perf_wr + 32'd1;
      end
      if (r_wr_valid && !wr_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_wr_count    = r_perf_wr;
  assign perf_stall_count = r_perf_stall;
`endif

  assign wr_valid     = r_wr_valid;
  assign wr_ns_sel    = r_ns_sel;
  assign wr_addr      = r_head_addr;
  assign fifo_count   = r_count;
  assign almost_full  = r_almost_full;
  assign overflow_err = r_overflow_err;
  assign busy         = r_busy;
  assign drain_done   = r_drain_done;

endmodule
